// File: rtl/elevator_bank.sv
`default_nettype none
// ============================================================================
// Module      : elevator_bank
// Description : Multi-car elevator controller with nearest-car dispatch and
//               per-car FIFO request queues.
// Revision    : 1.0
// ============================================================================
module elevator_bank #(
    parameter int N_CARS   = 2,
    parameter int FLOOR_W  = 4,
    parameter int N_FLOORS = 16,
    parameter int QDEPTH   = 4,
    parameter int MOVE_CYC = 4,
    parameter int DOOR_CYC = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    input  logic [FLOOR_W-1:0]                   req_floor,
    output logic                                 req_ready,
    output logic                                 req_err,
    output logic [N_CARS*FLOOR_W-1:0]            car_floor,
    output logic [N_CARS*2-1:0]                  car_dir,
    output logic [N_CARS-1:0]                    car_door,
    output logic [N_CARS*($clog2(QDEPTH)+1)-1:0] car_qcnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_e;

    localparam int c_ptr_w  = $clog2(QDEPTH);
    localparam int c_qcnt_w = $clog2(QDEPTH) + 1;
    localparam int c_mc_w   = $clog2(MOVE_CYC + 1);
    localparam int c_dc_w   = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

    localparam logic [FLOOR_W:0]    c_nfloors   = N_FLOORS[FLOOR_W:0];
    localparam logic [c_qcnt_w-1:0] c_qdepth    = QDEPTH[c_qcnt_w-1:0];
    localparam logic [c_mc_w-1:0]   c_mc_load   = c_mc_w'(MOVE_CYC);
    localparam logic [c_mc_w-1:0]   c_mc_reload = c_mc_w'(MOVE_CYC - 1);
    localparam logic [c_dc_w-1:0]   c_dc_load   = c_dc_w'(DOOR_CYC - 1);

    logic               run_q;
    logic               err_q;
    logic [FLOOR_W-1:0] w_floor  [N_CARS];
    logic [FLOOR_W-1:0] w_target [N_CARS];
    logic [FLOOR_W-1:0] w_last   [N_CARS];
    logic [N_CARS-1:0]  w_full;
    logic [N_CARS-1:0]  w_nempty;
    logic [N_CARS-1:0]  w_moving;
    logic [N_CARS-1:0]  w_onehot;
    logic [N_CARS-1:0]  w_push;
    logic               w_found;
    logic               w_dup;
    logic               w_in_range;
    logic               w_xfer;
    logic [FLOOR_W-1:0] w_dist;
    logic [FLOOR_W-1:0] w_best;

    // Strict '<' keeps the lowest-index car on equal distance.
    always_comb begin
        w_found  = 1'b0;
        w_dup    = 1'b0;
        w_onehot = '0;
        w_dist   = '0;
        w_best   = '0;
        for (int i = 0; i < N_CARS; i++) begin
            w_dist = (w_floor[i] >= req_floor) ? (w_floor[i] - req_floor)
                                               : (req_floor - w_floor[i]);
            if (!w_full[i] && (!w_found || (w_dist < w_best))) begin
                w_found     = 1'b1;
                w_best      = w_dist;
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_dup       = (w_nempty[i] && (w_last[i] == req_floor)) ||
                              (w_moving[i] && (w_target[i] == req_floor));
            end
        end
    end

    assign w_in_range = ({1'b0, req_floor} < c_nfloors);
    assign req_ready  = run_q & w_found;
    assign w_xfer     = req_valid & req_ready;
    assign w_push     = (w_xfer && w_in_range && !w_dup) ? w_onehot : '0;
    assign req_err    = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            err_q <= w_xfer & ~w_in_range;
        end
    end

    for (genvar gi = 0; gi < N_CARS; gi++) begin : g_car
        state_e              state_q, state_d;
        logic [FLOOR_W-1:0]  floor_q, floor_d;
        logic [FLOOR_W-1:0]  target_q, target_d;
        logic [c_mc_w-1:0]   mcnt_q, mcnt_d;
        logic [c_dc_w-1:0]   dcnt_q, dcnt_d;
        logic [FLOOR_W-1:0]  last_q;
        logic [c_ptr_w-1:0]  wptr_q, rptr_q;
        logic [c_qcnt_w-1:0] cnt_q;
        logic [FLOOR_W-1:0]  mem_q [QDEPTH];
        logic                w_pop;
        logic                w_up;
        logic [1:0]          w_dir;
        logic                w_door;

        assign w_pop = (state_q == S_IDLE) && (cnt_q != '0);
        assign w_up  = (target_q > floor_q);

        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                mem_q[wptr_q] <= req_floor;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                last_q <= '0;
            end else begin
                if (w_push[gi]) begin
                    wptr_q <= wptr_q + 1'b1;
                    last_q <= req_floor;
                end
                if (w_pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                case ({w_push[gi], w_pop})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        always_comb begin
            state_d  = state_q;
            floor_d  = floor_q;
            target_d = target_q;
            mcnt_d   = mcnt_q;
            dcnt_d   = dcnt_q;
            w_dir    = 2'b00;
            w_door   = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cnt_q != '0) begin
                        target_d = mem_q[rptr_q];
                        if (mem_q[rptr_q] == floor_q) begin
                            state_d = S_DOOR;
                            dcnt_d  = c_dc_load;
                        end else begin
                            state_d = S_MOVE;
                            mcnt_d  = c_mc_load;
                        end
                    end
                end
                S_MOVE: begin
                    w_dir = w_up ? 2'b01 : 2'b10;
                    if (mcnt_q == '0) begin
                        floor_d = w_up ? (floor_q + 1'b1) : (floor_q - 1'b1);
                        mcnt_d  = c_mc_reload;
                        if (floor_d == target_q) begin
                            state_d = S_DOOR;
                            dcnt_d  = c_dc_load;
                        end
                    end else begin
                        mcnt_d = mcnt_q - 1'b1;
                    end
                end
                S_DOOR: begin
                    w_door = 1'b1;
                    if (dcnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q  <= S_IDLE;
                floor_q  <= '0;
                target_q <= '0;
                mcnt_q   <= '0;
                dcnt_q   <= '0;
            end else begin
                state_q  <= state_d;
                floor_q  <= floor_d;
                target_q <= target_d;
                mcnt_q   <= mcnt_d;
                dcnt_q   <= dcnt_d;
            end
        end

        assign w_floor[gi]  = floor_q;
        assign w_target[gi] = target_q;
        assign w_last[gi]   = last_q;
        assign w_full[gi]   = (cnt_q == c_qdepth);
        assign w_nempty[gi] = (cnt_q != '0);
        assign w_moving[gi] = (state_q == S_MOVE);

        assign car_floor[gi*FLOOR_W +: FLOOR_W]    = floor_q;
        assign car_dir[gi*2 +: 2]                  = w_dir;
        assign car_door[gi]                        = w_door;
        assign car_qcnt[gi*c_qcnt_w +: c_qcnt_w]   = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_bank
// Description : Directed self-checking bench for elevator_bank.
// Revision    : 1.0
// ============================================================================
module tb_elevator_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_floor;
    logic       req_ready;
    logic       req_err;
    logic [7:0] car_floor;
    logic [3:0] car_dir;
    logic [1:0] car_door;
    logic [5:0] car_qcnt;

    logic       v12;
    logic [3:0] f12;
    logic       rdy12;
    logic       err12;
    logic [7:0] floor12;
    logic [3:0] dir12;
    logic [1:0] door12;
    logic [5:0] qcnt12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elevator_bank #(
        .N_CARS(2), .FLOOR_W(4), .N_FLOORS(16), .QDEPTH(4), .MOVE_CYC(2), .DOOR_CYC(3)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
        .req_ready(req_ready), .req_err(req_err), .car_floor(car_floor),
        .car_dir(car_dir), .car_door(car_door), .car_qcnt(car_qcnt)
    );

    elevator_bank #(
        .N_CARS(2), .FLOOR_W(4), .N_FLOORS(12), .QDEPTH(4), .MOVE_CYC(2), .DOOR_CYC(3)
    ) dut12 (
        .clk(clk), .rst(rst), .req_valid(v12), .req_floor(f12),
        .req_ready(rdy12), .req_err(err12), .car_floor(floor12),
        .car_dir(dir12), .car_door(door12), .car_qcnt(qcnt12)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_floor = '0; v12 = 1'b0; f12 = '0;
        repeat (3) step();
        n_checks++; if (car_floor !== 8'h00) begin n_fail++; $display("FAIL reset_floor got %h want 00", car_floor); end
        n_checks++; if (car_dir !== 4'h0) begin n_fail++; $display("FAIL reset_dir got %h want 0", car_dir); end
        n_checks++; if (car_door !== 2'b00) begin n_fail++; $display("FAIL reset_door got %b want 00", car_door); end
        n_checks++; if (car_qcnt !== 6'o00) begin n_fail++; $display("FAIL reset_qcnt got %o want 00", car_qcnt); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", req_ready); end
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", req_err); end
        rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early got %b want 0", req_ready); end
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", req_ready); end
        n_checks++; if (rdy12 !== 1'b1) begin n_fail++; $display("FAIL release_ready12 got %b want 1", rdy12); end
    endtask

    task automatic test_single_trip();
        int ef;
        logic [1:0] ed;
        logic eo;
        req_valid = 1'b1; req_floor = 4'd5;
        step();
        req_valid = 1'b0;
        n_checks++; if (car_qcnt !== {3'd0, 3'd1}) begin n_fail++; $display("FAIL trip_push qcnt got %o want 01", car_qcnt); end
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL trip_err got %b want 0", req_err); end
        for (int k = 1; k <= 16; k++) begin
            step();
            ef = (k < 4) ? 0 : ((k >= 12) ? 5 : 1 + (k - 4) / 2);
            ed = (k <= 11) ? 2'b01 : 2'b00;
            eo = (k >= 12 && k <= 14);
            n_checks++; if (car_floor[3:0] !== 4'(ef)) begin n_fail++; $display("FAIL trip_floor k=%0d got %0d want %0d", k, car_floor[3:0], ef); end
            n_checks++; if (car_dir[1:0] !== ed) begin n_fail++; $display("FAIL trip_dir k=%0d got %b want %b", k, car_dir[1:0], ed); end
            n_checks++; if (car_door[0] !== eo) begin n_fail++; $display("FAIL trip_door k=%0d got %b want %b", k, car_door[0], eo); end
        end
        n_checks++; if (car_floor[7:4] !== 4'd0) begin n_fail++; $display("FAIL trip_car1_floor got %0d want 0", car_floor[7:4]); end
    endtask

    task automatic test_dispatch();
        req_valid = 1'b1; req_floor = 4'd1;
        step();
        req_floor = 4'd7;
        n_checks++; if (car_qcnt !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL disp_near1 qcnt got %o want 10", car_qcnt); end
        step();
        req_valid = 1'b0;
        n_checks++; if (car_qcnt !== {3'd0, 3'd1}) begin n_fail++; $display("FAIL disp_near7 qcnt got %o want 01", car_qcnt); end
        n_checks++; if (car_dir[3:2] !== 2'b01) begin n_fail++; $display("FAIL disp_car1_dir got %b want 01", car_dir[3:2]); end
        step();
        n_checks++; if (car_dir[1:0] !== 2'b01) begin n_fail++; $display("FAIL disp_car0_dir got %b want 01", car_dir[1:0]); end
        repeat (2) step();
        n_checks++; if (car_floor[7:4] !== 4'd1) begin n_fail++; $display("FAIL disp_car1_floor got %0d want 1", car_floor[7:4]); end
        n_checks++; if (car_door[1] !== 1'b1) begin n_fail++; $display("FAIL disp_car1_door got %b want 1", car_door[1]); end
        repeat (3) step();
        n_checks++; if (car_floor[3:0] !== 4'd7) begin n_fail++; $display("FAIL disp_car0_floor got %0d want 7", car_floor[3:0]); end
        n_checks++; if (car_door !== 2'b01) begin n_fail++; $display("FAIL disp_doors got %b want 01", car_door); end
        repeat (5) step();
        n_checks++; if (car_floor !== 8'h17) begin n_fail++; $display("FAIL disp_final_floor got %h want 17", car_floor); end
        n_checks++; if (car_dir !== 4'h0 || car_door !== 2'b00) begin n_fail++; $display("FAIL disp_final_idle got dir=%h door=%b want 0/00", car_dir, car_door); end
    endtask

    task automatic test_duplicate();
        req_valid = 1'b1; req_floor = 4'd3;
        step();
        n_checks++; if (car_qcnt !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL dup_first qcnt got %o want 10", car_qcnt); end
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL dup_first_err got %b want 0", req_err); end
        step();
        req_valid = 1'b0;
        n_checks++; if (car_qcnt !== 6'o00) begin n_fail++; $display("FAIL dup_second qcnt got %o want 00", car_qcnt); end
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL dup_second_err got %b want 0", req_err); end
        n_checks++; if (car_dir[3:2] !== 2'b01) begin n_fail++; $display("FAIL dup_car1_dir got %b want 01", car_dir[3:2]); end
        repeat (9) step();
        n_checks++; if (car_floor !== 8'h37) begin n_fail++; $display("FAIL dup_final_floor got %h want 37", car_floor); end
        n_checks++; if (car_door !== 2'b00) begin n_fail++; $display("FAIL dup_final_door got %b want 00", car_door); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [10];
        seq = '{4'd15, 4'd0, 4'd12, 4'd13, 4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5};
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_floor = seq[i];
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d got %b want 1", i, req_ready); end
            step();
            if (i == 0) begin
                n_checks++; if (car_qcnt !== {3'd0, 3'd1} || req_err !== 1'b0) begin n_fail++; $display("FAIL b2b_floor15 qcnt=%o err=%b want 01/0", car_qcnt, req_err); end
            end
        end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %b want 0", req_ready); end
        n_checks++; if (car_qcnt !== {3'd4, 3'd4}) begin n_fail++; $display("FAIL b2b_full_qcnt got %o want 44", car_qcnt); end
        req_floor = 4'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_held i=%0d got %b want 0", i, req_ready); end
        end
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_after_pop_ready got %b want 1", req_ready); end
        n_checks++; if (car_qcnt !== {3'd3, 3'd4}) begin n_fail++; $display("FAIL b2b_after_pop_qcnt got %o want 34", car_qcnt); end
        step();
        req_valid = 1'b0;
        n_checks++; if (car_qcnt !== {3'd4, 3'd4}) begin n_fail++; $display("FAIL b2b_ninth_qcnt got %o want 44", car_qcnt); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ninth_ready got %b want 0", req_ready); end
    endtask

    task automatic test_reset_mid_move();
        #2; rst = 1'b0; #1;
        n_checks++; if (car_floor !== 8'h00 || car_dir !== 4'h0) begin n_fail++; $display("FAIL rst_busy floor=%h dir=%h want 00/0", car_floor, car_dir); end
        n_checks++; if (car_qcnt !== 6'o00 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy qcnt=%o ready=%b want 00/0", car_qcnt, req_ready); end
        step(); step();
        rst = 1'b1;
        step();
        req_valid = 1'b1; req_floor = 4'd10;
        step();
        n_checks++; if (car_qcnt !== {3'd0, 3'd1}) begin n_fail++; $display("FAIL rmm_q1 got %o want 01", car_qcnt); end
        req_floor = 4'd11;
        step();
        n_checks++; if (car_qcnt !== {3'd0, 3'd1}) begin n_fail++; $display("FAIL rmm_q2 got %o want 01", car_qcnt); end
        req_floor = 4'd12;
        step();
        req_valid = 1'b0;
        n_checks++; if (car_qcnt !== {3'd0, 3'd2}) begin n_fail++; $display("FAIL rmm_q3 got %o want 02", car_qcnt); end
        repeat (6) step();
        n_checks++; if (car_floor[3:0] !== 4'd3 || car_dir[1:0] !== 2'b01) begin n_fail++; $display("FAIL rmm_at3 floor=%0d dir=%b want 3/01", car_floor[3:0], car_dir[1:0]); end
        #2; rst = 1'b0; #1;
        n_checks++; if (car_floor !== 8'h00 || car_dir !== 4'h0 || car_door !== 2'b00) begin n_fail++; $display("FAIL rmm_async floor=%h dir=%h door=%b want 00/0/00", car_floor, car_dir, car_door); end
        n_checks++; if (car_qcnt !== 6'o00) begin n_fail++; $display("FAIL rmm_async_qcnt got %o want 00", car_qcnt); end
        step(); step();
        rst = 1'b1;
        repeat (20) step();
        n_checks++; if (car_floor !== 8'h00 || car_dir !== 4'h0 || car_door !== 2'b00) begin n_fail++; $display("FAIL rmm_stale floor=%h dir=%h door=%b want 00/0/00", car_floor, car_dir, car_door); end
        n_checks++; if (car_qcnt !== 6'o00 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmm_stale qcnt=%o ready=%b want 00/1", car_qcnt, req_ready); end
    endtask

    task automatic test_range();
        n_checks++; if (rdy12 !== 1'b1) begin n_fail++; $display("FAIL range_ready got %b want 1", rdy12); end
        v12 = 1'b1; f12 = 4'd13;
        step();
        v12 = 1'b0;
        n_checks++; if (err12 !== 1'b1) begin n_fail++; $display("FAIL range_err13 got %b want 1", err12); end
        n_checks++; if (qcnt12 !== 6'o00) begin n_fail++; $display("FAIL range_qcnt13 got %o want 00", qcnt12); end
        step();
        n_checks++; if (err12 !== 1'b0) begin n_fail++; $display("FAIL range_err_pulse got %b want 0", err12); end
        v12 = 1'b1; f12 = 4'd12;
        step();
        v12 = 1'b0;
        n_checks++; if (err12 !== 1'b1 || qcnt12 !== 6'o00) begin n_fail++; $display("FAIL range_err12 err=%b qcnt=%o want 1/00", err12, qcnt12); end
        v12 = 1'b1; f12 = 4'd11;
        step();
        v12 = 1'b0;
        n_checks++; if (err12 !== 1'b0 || qcnt12 !== {3'd0, 3'd1}) begin n_fail++; $display("FAIL range_ok11 err=%b qcnt=%o want 0/01", err12, qcnt12); end
    endtask

    initial begin
        test_reset();
        test_single_trip();
        test_dispatch();
        test_duplicate();
        test_back_to_back();
        test_reset_mid_move();
        test_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
